// File: rtl/deconv_mchnl_col_if.sv
// ---------------------------------------------------------------------------
// deconv_mchnl_col_if
// Bundles the input-beat and output-column handshakes of deconv_mchnl_col.
//   slave  : the engine side (consumes beats, produces columns)
//   master : the producer/consumer side (bench or upstream/downstream logic)
// Signals:
//   i_stride          runtime stride, sampled on the first beat of a group
//   i_weight_col      K signed taps, tap k at [k*BIT_WIDTH +: BIT_WIDTH]
//   i_feature_map_col F signed pixels, pixel i at [i*BIT_WIDTH +: BIT_WIDTH]
//   i_valid/o_ready   input beat handshake
//   i_last_chnl       beat closes the channel group
//   o_cmpl_deconv_col saturated output column, pixel p at [p*2*BIT_WIDTH +: 2*BIT_WIDTH]
//   o_col_len         number of valid pixels in the column
//   o_sat             some pixel of this column was clipped
//   o_valid/i_ready   output column handshake
// ---------------------------------------------------------------------------
interface deconv_mchnl_col_if #(
  parameter int BIT_WIDTH    = 8,
  parameter int WEIGHT_SIZE  = 5,
  parameter int FEATURE_SIZE = 8,
  parameter int STRIDE_MAX   = 2,
  parameter int N_PIX_OUT    = (FEATURE_SIZE - 1) * STRIDE_MAX + WEIGHT_SIZE
) ();
  localparam int SW = $clog2(STRIDE_MAX + 1);
  localparam int LW = $clog2(N_PIX_OUT + 1);

  logic [SW-1:0]                      i_stride;
  logic [BIT_WIDTH*WEIGHT_SIZE-1:0]   i_weight_col;
  logic [BIT_WIDTH*FEATURE_SIZE-1:0]  i_feature_map_col;
  logic                               i_valid;
  logic                               i_last_chnl;
  logic                               o_ready;
  logic [2*BIT_WIDTH*N_PIX_OUT-1:0]   o_cmpl_deconv_col;
  logic [LW-1:0]                      o_col_len;
  logic                               o_sat;
  logic                               o_valid;
  logic                               i_ready;

  modport slave (
    input  i_stride, i_weight_col, i_feature_map_col, i_valid, i_last_chnl, i_ready,
    output o_ready, o_cmpl_deconv_col, o_col_len, o_sat, o_valid
  );

  modport master (
    output i_stride, i_weight_col, i_feature_map_col, i_valid, i_last_chnl, i_ready,
    input  o_ready, o_cmpl_deconv_col, o_col_len, o_sat, o_valid
  );
endinterface

// File: rtl/deconv_mchnl_col.sv
// ---------------------------------------------------------------------------
// deconv_mchnl_col
// Multi-channel transposed-convolution column engine with runtime stride.
// Each accepted beat's weight column (K taps) and feature column (F pixels)
// form an outer product that is scatter-added into acc[i*S+k]. Beats are
// summed across channels until the beat flagged last; the column is then
// saturated to 2*BIT_WIDTH bits and handed to a valid/ready output buffer.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   bus    deconv_mchnl_col_if.slave (input beats in, output columns out)
// Pipeline: beat -> product registers -> accumulator -> output buffer, so a
// last beat accepted in cycle t shows o_valid in cycle t+3 when the buffer is
// free.
// ---------------------------------------------------------------------------
module deconv_mchnl_col #(
  parameter int BIT_WIDTH    = 8,
  parameter int WEIGHT_SIZE  = 5,
  parameter int FEATURE_SIZE = 8,
  parameter int STRIDE_MAX   = 2,
  parameter int ACC_WIDTH    = 24,
  parameter int N_PIX_OUT    = (FEATURE_SIZE - 1) * STRIDE_MAX + WEIGHT_SIZE
) (
  input  logic               i_clk,
  input  logic               i_rst,
  deconv_mchnl_col_if.slave  bus
);
  localparam int PW = 2 * BIT_WIDTH;
  localparam int SW = $clog2(STRIDE_MAX + 1);
  localparam int LW = $clog2(N_PIX_OUT + 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (PW - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (PW - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic          accept;
  logic          load_col;
  logic          buf_free;
  logic [SW-1:0] stride_clamped;
  logic [SW-1:0] stride_eff;
  logic [SW-1:0] stride_reg;
  logic [SW-1:0] s1_stride_reg;
  logic          s1_valid_reg;
  logic [LW-1:0] col_len;

  logic signed [PW-1:0] prod_reg [FEATURE_SIZE][WEIGHT_SIZE];

  logic [PW*N_PIX_OUT-1:0] sat_col;
  logic [N_PIX_OUT-1:0]    clip_vec;

  logic [PW*N_PIX_OUT-1:0] out_col_reg;
  logic [LW-1:0]           out_len_reg;
  logic                    out_sat_reg;
  logic                    out_valid_reg;

  // Held low during reset so nothing is accepted while state is being cleared.
  assign bus.o_ready = !i_rst && (state_reg != FLUSH);
  assign accept      = bus.i_valid && bus.o_ready;
  assign buf_free    = !out_valid_reg || bus.i_ready;
  // The accumulator is final only once the product stage holds nothing.
  assign load_col    = (state_reg == FLUSH) && !s1_valid_reg && buf_free;

  always_comb begin
    stride_clamped = bus.i_stride;
    if (bus.i_stride == '0) begin
      stride_clamped = SW'(1);
    end else if (int'(bus.i_stride) > STRIDE_MAX) begin
      stride_clamped = SW'(STRIDE_MAX);
    end
  end

  // Only the first beat of a group picks the stride; later beats reuse it.
  assign stride_eff = (state_reg == IDLE) ? stride_clamped : stride_reg;
  assign col_len    = LW'((FEATURE_SIZE - 1) * int'(stride_reg) + WEIGHT_SIZE);

  // FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = bus.i_last_chnl ? FLUSH : ACC;
      ACC:     if (accept && bus.i_last_chnl) state_next = FLUSH;
      FLUSH:   if (load_col) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stride tracking and product-stage valid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stride_reg    <= SW'(1);
      s1_stride_reg <= SW'(1);
      s1_valid_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_stride_reg <= stride_eff;
        if (state_reg == IDLE) begin
          stride_reg <= stride_clamped;
        end
      end
    end
  end

  // Stage 1: all K*F signed products. Data-only registers; validity is
  // tracked by s1_valid_reg, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int i = 0; i < FEATURE_SIZE; i++) begin
        for (int k = 0; k < WEIGHT_SIZE; k++) begin
          prod_reg[i][k] <= $signed(bus.i_feature_map_col[i*BIT_WIDTH +: BIT_WIDTH]) *
                            $signed(bus.i_weight_col[k*BIT_WIDTH +: BIT_WIDTH]);
        end
      end
    end
  end

  // Stage 2: one accumulator per output pixel. Each pixel gathers exactly the
  // products whose scatter index i*S+k lands on it for the stride carried with
  // the products, so pixels beyond (F-1)*S+K receive nothing and stay zero.
  genvar gi;
  generate
    for (gi = 0; gi < N_PIX_OUT; gi++) begin : g_pix
      logic signed [ACC_WIDTH-1:0] acc_reg;
      logic signed [ACC_WIDTH-1:0] add_val;

      always_comb begin
        add_val = '0;
        for (int s = 1; s <= STRIDE_MAX; s++) begin
          for (int i = 0; i < FEATURE_SIZE; i++) begin
            for (int k = 0; k < WEIGHT_SIZE; k++) begin
              if ((int'(s1_stride_reg) == s) && (i * s + k == gi)) begin
                add_val = add_val + ACC_WIDTH'(prod_reg[i][k]);
              end
            end
          end
        end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          acc_reg <= '0;
        end else if (load_col) begin
          acc_reg <= '0;
        end else if (s1_valid_reg) begin
          acc_reg <= acc_reg + add_val;
        end
      end

      assign clip_vec[gi] = (acc_reg > SAT_MAX) || (acc_reg < SAT_MIN);
      assign sat_col[gi*PW +: PW] = (acc_reg > SAT_MAX) ? SAT_MAX[PW-1:0] :
                                    (acc_reg < SAT_MIN) ? SAT_MIN[PW-1:0] :
                                                          acc_reg[PW-1:0];
    end
  endgenerate

  // Output buffer: loads on the same edge that clears the accumulator, which
  // may also be the edge of a downstream handshake (o_valid then stays high).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_col_reg   <= '0;
      out_len_reg   <= '0;
      out_sat_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else if (load_col) begin
      out_col_reg   <= sat_col;
      out_len_reg   <= col_len;
      out_sat_reg   <= |clip_vec;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && bus.i_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.o_cmpl_deconv_col = out_col_reg;
  assign bus.o_col_len         = out_len_reg;
  assign bus.o_sat             = out_sat_reg;
  assign bus.o_valid           = out_valid_reg;
endmodule

// File: tb/tb_deconv_mchnl_col.sv
// ---------------------------------------------------------------------------
// tb_deconv_mchnl_col
// Self-checking bench for deconv_mchnl_col. A reference model accumulates
// every accepted beat and pushes the expected column when the last beat of a
// group is accepted; a monitor pops and compares on every output handshake.
// Scenario tasks add their own directed checks on latency, values and
// handshake behaviour.
// ---------------------------------------------------------------------------
module tb_deconv_mchnl_col;
  localparam int BW   = 8;
  localparam int K    = 5;
  localparam int F    = 8;
  localparam int SMAX = 2;
  localparam int AW   = 24;
  localparam int NP   = (F - 1) * SMAX + K;
  localparam int PW   = 2 * BW;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int LW   = $clog2(NP + 1);

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  typedef struct {
    logic [PW*NP-1:0] col;
    logic [LW-1:0]    len;
    logic             sat;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint macc [NP];
  int     g_stride;
  bit     g_open;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  deconv_mchnl_col_if #(
    .BIT_WIDTH(BW), .WEIGHT_SIZE(K), .FEATURE_SIZE(F), .STRIDE_MAX(SMAX), .N_PIX_OUT(NP)
  ) dif ();

  deconv_mchnl_col #(
    .BIT_WIDTH(BW), .WEIGHT_SIZE(K), .FEATURE_SIZE(F), .STRIDE_MAX(SMAX),
    .ACC_WIDTH(AW), .N_PIX_OUT(NP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (dif)
  );

  // ---------------- helpers ----------------
  function automatic int pix(input int p);
    logic [PW*NP-1:0] c;
    c = dif.o_cmpl_deconv_col;
    return int'($signed(c[p*PW +: PW]));
  endfunction

  function automatic logic [BW*K-1:0] fill_w(input int v);
    logic [BW*K-1:0] r;
    for (int k = 0; k < K; k++) r[k*BW +: BW] = BW'(v);
    return r;
  endfunction

  function automatic logic [BW*F-1:0] fill_f(input int v);
    logic [BW*F-1:0] r;
    for (int i = 0; i < F; i++) r[i*BW +: BW] = BW'(v);
    return r;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) macc[p] = 0;
    g_open = 1'b0;
  endtask

  task automatic model_beat(input logic [BW*K-1:0] w, input logic [BW*F-1:0] f,
                            input int stride, input bit last);
    exp_t   e;
    longint v;
    int     wk, fi;
    if (!g_open) begin
      g_stride = (stride == 0) ? 1 : ((stride > SMAX) ? SMAX : stride);
      g_open   = 1'b1;
    end
    for (int i = 0; i < F; i++) begin
      for (int k = 0; k < K; k++) begin
        wk = int'($signed(w[k*BW +: BW]));
        fi = int'($signed(f[i*BW +: BW]));
        macc[i*g_stride+k] += longint'(wk * fi);
      end
    end
    if (last) begin
      e.sat = 1'b0;
      e.col = '0;
      for (int p = 0; p < NP; p++) begin
        v = macc[p];
        if (v > 32767) begin v = 32767; e.sat = 1'b1; end
        if (v < -32768) begin v = -32768; e.sat = 1'b1; end
        e.col[p*PW +: PW] = PW'(v);
      end
      e.len = LW'((F - 1) * g_stride + K);
      exp_q.push_back(e);
      model_clear();
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [BW*K-1:0] w, input logic [BW*F-1:0] f,
                           input int stride, input bit last);
    int n = 0;
    dif.i_weight_col      = w;
    dif.i_feature_map_col = f;
    dif.i_stride          = SW'(stride);
    dif.i_last_chnl       = last;
    dif.i_valid           = 1'b1;
    while (!dif.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!dif.o_ready) begin
      n_checks++;
      $display("FAIL send_timeout: o_ready=%0b required 1 within 100 cycles", dif.o_ready);
    end else begin
      @(posedge clk);
      model_beat(w, f, stride, last);
      @(negedge clk);
    end
    dif.i_valid     = 1'b0;
    dif.i_last_chnl = 1'b0;
  endtask

  // Counts negedges until o_valid is seen.
  task automatic wait_valid(output int lat);
    int n = 0;
    while (!dif.o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dif.o_valid) begin
      n_checks++;
      $display("FAIL wait_valid: o_valid=%0b required 1 within 50 cycles", dif.o_valid);
    end
    lat = n;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    #1;
    if (!rst && dif.o_valid && dif.i_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL col_unexpected: got column len=%0d, required none", dif.o_col_len);
      end else begin
        mon_e = exp_q.pop_front();
        if (dif.o_cmpl_deconv_col === mon_e.col && dif.o_col_len === mon_e.len &&
            dif.o_sat === mon_e.sat) begin
          n_pass++;
          $display("column len=%0d sat=%0b pix0=%0d matches model", dif.o_col_len, dif.o_sat, pix(0));
        end else begin
          int bad = 0;
          for (int p = NP - 1; p >= 0; p--) begin
            if (dif.o_cmpl_deconv_col[p*PW +: PW] !== mon_e.col[p*PW +: PW]) bad = p;
          end
          $display("FAIL col_scoreboard: pix%0d got %0d required %0d, len got %0d required %0d, sat got %0b required %0b",
                   bad, pix(bad), int'($signed(mon_e.col[bad*PW +: PW])),
                   dif.o_col_len, mon_e.len, dif.o_sat, mon_e.sat);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dif.o_valid !== 1'b0 || dif.o_sat !== 1'b0 || dif.o_cmpl_deconv_col !== '0 || dif.o_col_len !== '0)
      $display("FAIL reset_outputs: valid=%0b sat=%0b len=%0d, required all zero", dif.o_valid, dif.o_sat, dif.o_col_len);
    else n_pass++;
    n_checks++;
    if (dif.o_ready !== 1'b0) $display("FAIL reset_ready: o_ready=%0b required 0", dif.o_ready);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (dif.o_ready !== 1'b1) $display("FAIL ready_after_reset: o_ready=%0b required 1", dif.o_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic check_ones_s2(input string tag);
    int lat;
    int exp5[5] = '{1, 1, 2, 2, 3};
    bit ok;
    send_beat(fill_w(1), fill_f(1), 2, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (lat !== 2) $display("FAIL %s_latency: o_valid after %0d further cycles, required 2", tag, lat);
    else n_pass++;
    n_checks++;
    if (dif.o_ready !== 1'b1) $display("FAIL %s_ready_back: o_ready=%0b required 1", tag, dif.o_ready);
    else n_pass++;
    n_checks++;
    if (dif.o_col_len !== LW'(19)) $display("FAIL %s_len: o_col_len=%0d required 19", tag, dif.o_col_len);
    else n_pass++;
    ok = 1'b1;
    for (int p = 0; p < 5; p++) if (pix(p) != exp5[p]) ok = 1'b0;
    if (pix(18) != 1) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL %s_pixels: pix0..4=%0d,%0d,%0d,%0d,%0d pix18=%0d required 1,1,2,2,3 and 1",
                      tag, pix(0), pix(1), pix(2), pix(3), pix(4), pix(18));
    else n_pass++;
    n_checks++;
    if (dif.o_sat !== 1'b0) $display("FAIL %s_sat: o_sat=%0b required 0", tag, dif.o_sat);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stride2_ones();
    check_ones_s2("s2_ones");
  endtask

  task automatic test_multi_chnl();
    int lat;
    bit ok;
    for (int c = 0; c < 3; c++) send_beat(fill_w(2), fill_f(3), 1, c == 2);
    wait_valid(lat);
    n_checks++;
    if (dif.o_col_len !== LW'(12)) $display("FAIL mc_len: o_col_len=%0d required 12", dif.o_col_len);
    else n_pass++;
    n_checks++;
    if (pix(0) != 18) $display("FAIL mc_pix0: got %0d required 18", pix(0));
    else n_pass++;
    ok = 1'b1;
    for (int p = 4; p < 8; p++) if (pix(p) != 90) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL mc_mid: pix4..7=%0d,%0d,%0d,%0d required 90", pix(4), pix(5), pix(6), pix(7));
    else n_pass++;
    ok = 1'b1;
    for (int p = 12; p < NP; p++) if (pix(p) != 0) ok = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL mc_tail: pix12=%0d pix18=%0d required 0", pix(12), pix(18));
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int lat;
    int pv[2]  = '{127, -128};
    int sv[2]  = '{32767, -32768};
    bit ok;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) send_beat(fill_w(127), fill_f(pv[r]), 1, c == 3);
      wait_valid(lat);
      ok = 1'b1;
      for (int p = 0; p < 12; p++) if (pix(p) != sv[r]) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL sat_value%0d: pix0=%0d pix5=%0d required %0d", r, pix(0), pix(5), sv[r]);
      else n_pass++;
      n_checks++;
      if (dif.o_sat !== 1'b1) $display("FAIL sat_flag%0d: o_sat=%0b required 1", r, dif.o_sat);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [BW*K-1:0]  wa, wb;
    logic [BW*F-1:0]  fa, fb;
    logic [PW*NP-1:0] col_a;
    logic [LW-1:0]    len_a;
    logic             sat_a;
    bit stable, ready_low;
    for (int k = 0; k < K; k++) begin
      wa[k*BW +: BW] = BW'($urandom_range(255));
      wb[k*BW +: BW] = BW'($urandom_range(255));
    end
    for (int i = 0; i < F; i++) begin
      fa[i*BW +: BW] = BW'($urandom_range(255));
      fb[i*BW +: BW] = BW'($urandom_range(255));
    end
    dif.i_ready = 1'b0;
    send_beat(wa, fa, 1, 1'b1);
    wait_valid(lat);
    col_a = dif.o_cmpl_deconv_col;
    len_a = dif.o_col_len;
    sat_a = dif.o_sat;
    n_checks++;
    if (len_a !== LW'(12)) $display("FAIL bp_len_a: o_col_len=%0d required 12", len_a);
    else n_pass++;
    send_beat(wb, fb, 2, 1'b1);
    stable    = 1'b1;
    ready_low = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (dif.o_valid !== 1'b1 || dif.o_cmpl_deconv_col !== col_a ||
          dif.o_col_len !== len_a || dif.o_sat !== sat_a) stable = 1'b0;
      if (dif.o_ready !== 1'b0) ready_low = 1'b0;
    end
    n_checks++;
    if (!stable) $display("FAIL bp_hold: valid=%0b len=%0d, required 1 and %0d held", dif.o_valid, dif.o_col_len, len_a);
    else n_pass++;
    n_checks++;
    if (!ready_low) $display("FAIL bp_ready: o_ready=%0b required 0 while blocked", dif.o_ready);
    else n_pass++;
    dif.i_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dif.o_valid !== 1'b1 || dif.o_col_len !== LW'(19))
      $display("FAIL bp_second: valid=%0b len=%0d required 1 and 19", dif.o_valid, dif.o_col_len);
    else n_pass++;
    n_checks++;
    if (dif.o_ready !== 1'b1) $display("FAIL bp_ready_back: o_ready=%0b required 1", dif.o_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stride_latch();
    int lat;
    int strides[3] = '{2, 1, 1};
    logic [BW*K-1:0] w;
    logic [BW*F-1:0] f;
    for (int k = 0; k < K; k++) w[k*BW +: BW] = BW'(k + 1);
    for (int i = 0; i < F; i++) f[i*BW +: BW] = BW'(i + 1);
    for (int c = 0; c < 3; c++) send_beat(w, f, strides[c], c == 2);
    wait_valid(lat);
    n_checks++;
    if (dif.o_col_len !== LW'(19) || pix(2) != 15)
      $display("FAIL latch_s2: len=%0d pix2=%0d required 19 and 15", dif.o_col_len, pix(2));
    else n_pass++;
    @(negedge clk);
    send_beat(w, f, 0, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (dif.o_col_len !== LW'(12) || pix(2) != 10)
      $display("FAIL stride0_as1: len=%0d pix2=%0d required 12 and 10", dif.o_col_len, pix(2));
    else n_pass++;
    @(negedge clk);
    send_beat(w, f, 3, 1'b1);
    wait_valid(lat);
    n_checks++;
    if (dif.o_col_len !== LW'(19) || pix(2) != 5)
      $display("FAIL stride3_as2: len=%0d pix2=%0d required 19 and 5", dif.o_col_len, pix(2));
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    send_beat(fill_w(100), fill_f(-50), 2, 1'b0);
    send_beat(fill_w(-90), fill_f(77), 2, 1'b0);
    rst = 1'b1;
    model_clear();
    exp_q.delete();
    #1;
    n_checks++;
    if (dif.o_valid !== 1'b0 || dif.o_sat !== 1'b0 || dif.o_cmpl_deconv_col !== '0 ||
        dif.o_col_len !== '0 || dif.o_ready !== 1'b0)
      $display("FAIL midrst_outputs: valid=%0b sat=%0b len=%0d ready=%0b required all zero",
               dif.o_valid, dif.o_sat, dif.o_col_len, dif.o_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_ones_s2("after_rst");
  endtask

  // ---------------- main ----------------
  initial begin
    rst                   = 1'b1;
    dif.i_valid           = 1'b0;
    dif.i_last_chnl       = 1'b0;
    dif.i_stride          = '0;
    dif.i_weight_col      = '0;
    dif.i_feature_map_col = '0;
    dif.i_ready           = 1'b1;
    model_clear();
    g_stride = 1;

    test_reset();
    test_stride2_ones();
    test_multi_chnl();
    test_saturation();
    test_back_to_back();
    test_stride_latch();
    test_reset_mid();

    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d columns outstanding, required 0", exp_q.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/deconv_mchnl_col.md
# deconv_mchnl_col

Multi-channel, runtime-stride transposed-convolution column engine. Each accepted beat carries one weight column (WEIGHT_SIZE taps) and one feature-map column (FEATURE_SIZE pixels). The engine scatter-adds their outer product into a signed accumulator column, summing across input channels until the beat flagged last. It then saturates the sum, emits it through a valid/ready output buffer, and feeds the overlap processing stage downstream.

## Interface
Parameters:
- BIT_WIDTH, 8, signed weight/pixel width
- WEIGHT_SIZE, 5, kernel column length K
- FEATURE_SIZE, 8, feature column length F
- STRIDE_MAX, 2, largest supported stride
- ACC_WIDTH, 24, signed accumulator width (≥ 2*BIT_WIDTH+4)
- N_PIX_OUT, (FEATURE_SIZE-1)*STRIDE_MAX+WEIGHT_SIZE, output column length (19 at defaults)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_stride  in  $clog2(STRIDE_MAX+1)  stride S; sampled on first beat of a group
- i_weight_col  in  BIT_WIDTH*WEIGHT_SIZE  tap k at [k*BIT_WIDTH +: BIT_WIDTH]
- i_feature_map_col  in  BIT_WIDTH*FEATURE_SIZE  pixel i at [i*BIT_WIDTH +: BIT_WIDTH]
- i_valid  in  1  input beat valid
- i_last_chnl  in  1  beat is the last channel of the group
- o_ready  out  1  engine accepts a beat
- o_cmpl_deconv_col  out  2*BIT_WIDTH*N_PIX_OUT  pixel p at [p*2*BIT_WIDTH +: 2*BIT_WIDTH]
- o_col_len  out  $clog2(N_PIX_OUT+1)  valid pixels, (F-1)*S+K
- o_sat  out  1  saturation occurred in this column
- o_valid  out  1  output column valid
- i_ready  in  1  downstream accepts output

## Operation
- Beat accepted when i_valid && o_ready.
- Stride clamp: 0 → 1; values > STRIDE_MAX → STRIDE_MAX.
- Stride latch: taken from the first beat of a group and held until the group ends. i_stride on later beats is ignored.
- Stage 1: register all K*F signed products (2*BIT_WIDTH each).
- Stage 2: for every i,k, add product(i,k), sign-extended to ACC_WIDTH, into acc[i*S+k]. Entries p ≥ (F-1)*S+K stay 0.
- FSM states:
  - IDLE (accumulator zero): first beat moves to ACC, or to FLUSH if i_last_chnl.
  - ACC: beats accumulate; a beat with i_last_chnl moves to FLUSH.
  - FLUSH: o_ready=0. Once the pipeline has drained and the output buffer is free, the saturated accumulator is loaded into the buffer and the accumulator cleared in the same edge; FSM returns to IDLE.
- Output buffer is free when !o_valid, or o_valid && i_ready in that same cycle.
- Saturation: each entry clips to [-2^(2*BIT_WIDTH-1), 2^(2*BIT_WIDTH-1)-1]. o_sat = OR of any clip in the column. Accumulator itself never wraps within the ACC_WIDTH rule.
- Output handshake:
  - o_cmpl_deconv_col, o_col_len and o_sat stay stable while o_valid && !i_ready.
  - o_valid drops after an i_ready handshake unless a new column loads in the same edge.

## Timing
- Reset values:
  - o_valid=0, o_sat=0, o_cmpl_deconv_col=0, o_col_len=0
  - accumulator=0, FSM=IDLE
  - o_ready=0 while i_rst is high; 1 on the first cycle after deassert.
- Latency: last beat accepted at cycle t gives o_valid=1 at t+3 when the buffer is free; o_ready returns to 1 at t+3.
- Non-last beats: one per cycle, no bubbles.
- Output backpressure: o_valid high with i_ready low keeps FSM in FLUSH and o_ready=0 until the handshake. The buffer loads on the handshake edge, and o_valid stays 1 with the new column.
- Input hold: i_valid held while o_ready=0 is legal; data must hold until accepted.
- Reset mid-group: partial sums, pipeline and buffer are discarded. The next group's result must equal a fresh run.

## Test plan
- S=2, one channel, all weights 1, all pixels 1, last=1:
  - o_valid 3 cycles after acceptance, o_col_len=19
  - pixels 0..4 = 1,1,2,2,3; pixel 18 = 1; o_sat=0
- S=1, three channels, weights 2, pixels 3:
  - o_col_len=12, pixels 4..7 = 90, pixel 0 = 18, pixels 12..18 = 0
- S=1, four channels, weights 127, pixels 127:
  - all active pixels 32767 and o_sat=1
  - repeat with pixels -128 → -32768
- i_ready low, two back-to-back one-channel groups:
  - first column holds stable
  - o_ready stays 0 after second last beat until the handshake, then the second column appears the next cycle
- i_stride=2 on first beat, 1 on beats 2–3 of a 3-channel group:
  - result matches pure S=2; i_stride=0 behaves as 1; i_stride=3 as 2
- Assert i_rst two beats into a group:
  - all outputs return to reset values
  - subsequent one-channel group matches the first scenario exactly
